// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: decodes IR, drives datapath selects/enables,
// runs the memory port through a req/ready handshake.
// State encoding (visible on the debug port): FETCH=0 DECODE=1 EXEC=2 WB=3
// MEMADR=4 MEMRD=5 MEMWR=6 BRANCH=7 JUMP=8 TRAP=9.
// aluinst codes: ADD=0 SUB=1 AND=2 OR=3 XOR=4 NOR=5 SLT=6 SLTU=7 SLL=8 SRL=9
// SRA=10 LU=11 BNE=12 BLEZ=13 BGTZ=14 BLTZ=15.
module mc_ctrl #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  alusrc_a,
  output logic [2:0]  alusrc_b,
  output logic [3:0]  aluinst,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_src,
  output logic [3:0]  state,
  output logic        err
);

  localparam int unsigned OPW = 6;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LU   = 4'd11;
  localparam logic [3:0] ALU_BNE  = 4'd12;
  localparam logic [3:0] ALU_BLEZ = 4'd13;
  localparam logic [3:0] ALU_BGTZ = 4'd14;
  localparam logic [3:0] ALU_BLTZ = 4'd15;

  localparam logic [1:0] A_PC    = 2'd0;
  localparam logic [1:0] A_RS    = 2'd1;
  localparam logic [1:0] A_SHAMT = 2'd2;

  localparam logic [2:0] B_RT    = 3'd0;
  localparam logic [2:0] B_FOUR  = 3'd1;
  localparam logic [2:0] B_SEXT  = 3'd2;
  localparam logic [2:0] B_ZEXT  = 3'd3;
  localparam logic [2:0] B_SEXT2 = 3'd4;

  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JTGT   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic [OPW-1:0] OP_RTYPE  = 6'h00;
  localparam logic [OPW-1:0] OP_REGIMM = 6'h01;
  localparam logic [OPW-1:0] OP_JAL    = 6'h03;
  localparam logic [OPW-1:0] OP_LW     = 6'h23;
  localparam logic [OPW-1:0] OP_SW     = 6'h2B;
  localparam logic [OPW-1:0] FN_JALR   = 6'h09;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_WB     = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWR  = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8,
    S_TRAP   = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    C_ILL, C_EXEC, C_MEM, C_BRANCH, C_JUMP
  } class_e;

  state_e         state_q, state_d;
  class_e         dec_class;
  logic [3:0]     exec_op, br_op;
  logic [1:0]     exec_a;
  logic [2:0]     exec_b;
  logic [OPW-1:0] opcode, funct;
  logic [4:0]     rt;
  logic           unused_instr;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rt     = instr[20:16];
  // register and immediate fields feed the datapath, not the control
  assign unused_instr = ^{instr[25:21], instr[15:6]};

  assign state = state_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Instruction decode: class plus EXEC/BRANCH operand selection and ALU op
  always_comb begin
    dec_class = C_ILL;
    exec_op   = ALU_ADD;
    exec_a    = A_RS;
    exec_b    = B_RT;
    br_op     = ALU_SUB;
    case (opcode)
      OP_RTYPE: begin
        dec_class = C_EXEC;
        case (funct)
          6'h20, 6'h21: exec_op = ALU_ADD;
          6'h22, 6'h23: exec_op = ALU_SUB;
          6'h24: exec_op = ALU_AND;
          6'h25: exec_op = ALU_OR;
          6'h26: exec_op = ALU_XOR;
          6'h27: exec_op = ALU_NOR;
          6'h2A: exec_op = ALU_SLT;
          6'h2B: exec_op = ALU_SLTU;
          6'h00: begin exec_op = ALU_SLL; exec_a = A_SHAMT; end
          6'h02: begin exec_op = ALU_SRL; exec_a = A_SHAMT; end
          6'h03: begin exec_op = ALU_SRA; exec_a = A_SHAMT; end
          6'h04: exec_op = ALU_SLL;
          6'h06: exec_op = ALU_SRL;
          6'h07: exec_op = ALU_SRA;
          6'h08, 6'h09: dec_class = C_JUMP;
          default: dec_class = C_ILL;
        endcase
      end
      OP_REGIMM: begin
        br_op = ALU_BLTZ;
        if (rt == 5'd0 || rt == 5'd1) dec_class = C_BRANCH;
      end
      6'h02, 6'h03: dec_class = C_JUMP;
      6'h04: dec_class = C_BRANCH;
      6'h05: begin dec_class = C_BRANCH; br_op = ALU_BNE;  end
      6'h06: begin dec_class = C_BRANCH; br_op = ALU_BLEZ; end
      6'h07: begin dec_class = C_BRANCH; br_op = ALU_BGTZ; end
      6'h08, 6'h09: begin dec_class = C_EXEC; exec_op = ALU_ADD;  exec_b = B_SEXT; end
      6'h0A: begin dec_class = C_EXEC; exec_op = ALU_SLT;  exec_b = B_SEXT; end
      6'h0B: begin dec_class = C_EXEC; exec_op = ALU_SLTU; exec_b = B_SEXT; end
      6'h0C: begin dec_class = C_EXEC; exec_op = ALU_AND;  exec_b = B_ZEXT; end
      6'h0D: begin dec_class = C_EXEC; exec_op = ALU_OR;   exec_b = B_ZEXT; end
      6'h0E: begin dec_class = C_EXEC; exec_op = ALU_XOR;  exec_b = B_ZEXT; end
      6'h0F: begin dec_class = C_EXEC; exec_op = ALU_LU;   exec_b = B_ZEXT; end
      OP_LW, OP_SW: dec_class = C_MEM;
      default: dec_class = C_ILL;
    endcase
  end

  // Next state and datapath controls from the registered state
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 2'd0;
    alusrc_a = A_PC;
    alusrc_b = B_RT;
    aluinst  = ALU_ADD;
    reg_we   = 1'b0;
    reg_dst  = DST_RT;
    wb_src   = 2'd0;
    err      = 1'b0;
    case (state_q)
      S_FETCH: begin
        // gated by rst_n so an in-flight request drops as soon as reset asserts
        if (rst_n) begin
          mem_req  = 1'b1;
          alusrc_b = B_FOUR;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        alusrc_b = B_SEXT2;
        case (dec_class)
          C_EXEC:   state_d = S_EXEC;
          C_MEM:    state_d = S_MEMADR;
          C_BRANCH: state_d = S_BRANCH;
          C_JUMP:   state_d = S_JUMP;
          default:  state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_EXEC: begin
        alusrc_a = exec_a;
        alusrc_b = exec_b;
        aluinst  = exec_op;
        state_d  = S_WB;
      end
      S_WB: begin
        reg_we  = 1'b1;
        reg_dst = (opcode == OP_RTYPE) ? DST_RD : DST_RT;
        state_d = S_FETCH;
      end
      S_MEMADR: begin
        alusrc_a = A_RS;
        alusrc_b = B_SEXT;
        state_d  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          reg_we  = 1'b1;
          wb_src  = WB_MDR;
          state_d = S_FETCH;
        end
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alusrc_a = A_RS;
        aluinst  = br_op;
        pc_src   = PC_ALUOUT;
        pc_we    = zero;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pc_we = 1'b1;
        if (opcode == OP_RTYPE) begin
          pc_src = PC_RS;
          if (funct == FN_JALR) begin
            reg_we  = 1'b1;
            reg_dst = DST_RD;
            wb_src  = WB_PC;
          end
        end else begin
          pc_src = PC_JTGT;
          if (opcode == OP_JAL) begin
            reg_we  = 1'b1;
            reg_dst = DST_R31;
            wb_src  = WB_PC;
          end
        end
        state_d = S_FETCH;
      end
      S_TRAP: err = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed cases plus random instruction stream, checked
// against an instruction-level model of the expected control sequence.
module tb_mc_ctrl;

  localparam logic [3:0] A_ADD = 4'd0,  A_SUB = 4'd1,  A_AND = 4'd2,  A_OR   = 4'd3;
  localparam logic [3:0] A_XOR = 4'd4,  A_NOR = 4'd5,  A_SLT = 4'd6,  A_SLTU = 4'd7;
  localparam logic [3:0] A_SLL = 4'd8,  A_SRL = 4'd9,  A_SRA = 4'd10, A_LU   = 4'd11;
  localparam logic [3:0] A_BNE = 4'd12, A_BLEZ = 4'd13, A_BGTZ = 4'd14, A_BLTZ = 4'd15;

  localparam logic [5:0] R_FN [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                       6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

  typedef enum logic [3:0] {K_ALU, K_LW, K_SW, K_BR, K_J, K_JAL, K_JR, K_JALR, K_ILL} kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [3:0] op;
    logic [1:0] a;
    logic [2:0] b;
    logic       rtype;
  } info_t;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0] pc_src, alusrc_a;
    logic [2:0] alusrc_b;
    logic [3:0] aluinst;
    logic       reg_we;
    logic [1:0] reg_dst, wb_src;
    logic [3:0] state;
    logic       err;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n, zero, mem_ready;
  logic [31:0] instr;

  logic mem_req, mem_we, iord, ir_we, pc_we, reg_we, err;
  logic [1:0] pc_src, alusrc_a, reg_dst, wb_src;
  logic [2:0] alusrc_b;
  logic [3:0] aluinst, state;

  logic n_mem_req, n_mem_we, n_iord, n_ir_we, n_pc_we, n_reg_we, n_err;
  logic [1:0] n_pc_src, n_alusrc_a, n_reg_dst, n_wb_src;
  logic [2:0] n_alusrc_b;
  logic [3:0] n_aluinst, n_state;

  outs_t act, act_nt;
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mc_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluinst(aluinst),
    .reg_we(reg_we), .reg_dst(reg_dst), .wb_src(wb_src), .state(state), .err(err)
  );

  mc_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) u_nt (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(n_mem_req), .mem_we(n_mem_we), .iord(n_iord), .ir_we(n_ir_we), .pc_we(n_pc_we),
    .pc_src(n_pc_src), .alusrc_a(n_alusrc_a), .alusrc_b(n_alusrc_b), .aluinst(n_aluinst),
    .reg_we(n_reg_we), .reg_dst(n_reg_dst), .wb_src(n_wb_src), .state(n_state), .err(n_err)
  );

  assign act = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alusrc_a, alusrc_b, aluinst,
                reg_we, reg_dst, wb_src, state, err};
  assign act_nt = {n_mem_req, n_mem_we, n_iord, n_ir_we, n_pc_we, n_pc_src, n_alusrc_a,
                   n_alusrc_b, n_aluinst, n_reg_we, n_reg_dst, n_wb_src, n_state, n_err};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic info_t mk(input kind_t k, input logic [3:0] op, input logic [1:0] a,
                               input logic [2:0] b, input logic rtype);
    info_t r;
    r.kind = k; r.op = op; r.a = a; r.b = b; r.rtype = rtype;
    return r;
  endfunction

  function automatic info_t classify(input logic [31:0] ins);
    logic [5:0] opc, fn;
    logic [4:0] rt;
    info_t r;
    opc = ins[31:26]; fn = ins[5:0]; rt = ins[20:16];
    r = mk(K_ILL, A_ADD, 2'd1, 3'd0, 1'b0);
    if (opc == 6'h00) begin
      case (fn)
        6'h20, 6'h21: r = mk(K_ALU, A_ADD,  2'd1, 3'd0, 1'b1);
        6'h22, 6'h23: r = mk(K_ALU, A_SUB,  2'd1, 3'd0, 1'b1);
        6'h24: r = mk(K_ALU, A_AND,  2'd1, 3'd0, 1'b1);
        6'h25: r = mk(K_ALU, A_OR,   2'd1, 3'd0, 1'b1);
        6'h26: r = mk(K_ALU, A_XOR,  2'd1, 3'd0, 1'b1);
        6'h27: r = mk(K_ALU, A_NOR,  2'd1, 3'd0, 1'b1);
        6'h2A: r = mk(K_ALU, A_SLT,  2'd1, 3'd0, 1'b1);
        6'h2B: r = mk(K_ALU, A_SLTU, 2'd1, 3'd0, 1'b1);
        6'h00: r = mk(K_ALU, A_SLL,  2'd2, 3'd0, 1'b1);
        6'h02: r = mk(K_ALU, A_SRL,  2'd2, 3'd0, 1'b1);
        6'h03: r = mk(K_ALU, A_SRA,  2'd2, 3'd0, 1'b1);
        6'h04: r = mk(K_ALU, A_SLL,  2'd1, 3'd0, 1'b1);
        6'h06: r = mk(K_ALU, A_SRL,  2'd1, 3'd0, 1'b1);
        6'h07: r = mk(K_ALU, A_SRA,  2'd1, 3'd0, 1'b1);
        6'h08: r.kind = K_JR;
        6'h09: r.kind = K_JALR;
        default: ;
      endcase
    end else if (opc >= 6'h08 && opc <= 6'h0F) begin
      // 08-0B sign-extend, 0C-0F zero-extend
      r = mk(K_ALU, A_ADD, 2'd1, (opc < 6'h0C) ? 3'd2 : 3'd3, 1'b0);
      if (opc == 6'h0A) r.op = A_SLT;
      if (opc == 6'h0B) r.op = A_SLTU;
      if (opc == 6'h0C) r.op = A_AND;
      if (opc == 6'h0D) r.op = A_OR;
      if (opc == 6'h0E) r.op = A_XOR;
      if (opc == 6'h0F) r.op = A_LU;
    end else if (opc == 6'h04) r = mk(K_BR, A_SUB,  2'd1, 3'd0, 1'b0);
    else if (opc == 6'h05)     r = mk(K_BR, A_BNE,  2'd1, 3'd0, 1'b0);
    else if (opc == 6'h06)     r = mk(K_BR, A_BLEZ, 2'd1, 3'd0, 1'b0);
    else if (opc == 6'h07)     r = mk(K_BR, A_BGTZ, 2'd1, 3'd0, 1'b0);
    else if (opc == 6'h01 && rt < 5'd2) r = mk(K_BR, A_BLTZ, 2'd1, 3'd0, 1'b0);
    else if (opc == 6'h02) r.kind = K_J;
    else if (opc == 6'h03) r.kind = K_JAL;
    else if (opc == 6'h23) r.kind = K_LW;
    else if (opc == 6'h2B) r.kind = K_SW;
    return r;
  endfunction

  function automatic outs_t base(input logic [3:0] st);
    outs_t o;
    o = '0;
    o.aluinst = A_ADD;
    o.state = st;
    return o;
  endfunction

  function automatic outs_t e_fetch(input logic rdy);
    outs_t o;
    o = base(4'd0); o.mem_req = 1'b1; o.alusrc_b = 3'd1; o.ir_we = rdy; o.pc_we = rdy;
    return o;
  endfunction

  function automatic outs_t e_decode();
    outs_t o;
    o = base(4'd1); o.alusrc_b = 3'd4;
    return o;
  endfunction

  function automatic outs_t e_exec(input info_t inf);
    outs_t o;
    o = base(4'd2); o.alusrc_a = inf.a; o.alusrc_b = inf.b; o.aluinst = inf.op;
    return o;
  endfunction

  function automatic outs_t e_wb(input logic rtype);
    outs_t o;
    o = base(4'd3); o.reg_we = 1'b1; o.reg_dst = rtype ? 2'd1 : 2'd0;
    return o;
  endfunction

  function automatic outs_t e_memadr();
    outs_t o;
    o = base(4'd4); o.alusrc_a = 2'd1; o.alusrc_b = 3'd2;
    return o;
  endfunction

  function automatic outs_t e_mem(input logic wr, input logic rdy);
    outs_t o;
    o = base(wr ? 4'd6 : 4'd5); o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = wr;
    if (!wr && rdy) begin o.reg_we = 1'b1; o.wb_src = 2'd1; end
    return o;
  endfunction

  function automatic outs_t e_branch(input info_t inf, input logic z);
    outs_t o;
    o = base(4'd7); o.alusrc_a = 2'd1; o.aluinst = inf.op; o.pc_src = 2'd1; o.pc_we = z;
    return o;
  endfunction

  function automatic outs_t e_jump(input kind_t k);
    outs_t o;
    o = base(4'd8); o.pc_we = 1'b1;
    o.pc_src = (k == K_JR || k == K_JALR) ? 2'd3 : 2'd2;
    if (k == K_JAL)  begin o.reg_we = 1'b1; o.reg_dst = 2'd2; o.wb_src = 2'd2; end
    if (k == K_JALR) begin o.reg_we = 1'b1; o.reg_dst = 2'd1; o.wb_src = 2'd2; end
    return o;
  endfunction

  function automatic outs_t e_trap();
    outs_t o;
    o = base(4'd9); o.err = 1'b1;
    return o;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] gen_instr(input int cat);
    logic [31:0] w;
    int k;
    w = $urandom;
    k = int'($urandom_range(0, 4));
    case (cat)
      0: begin w[31:26] = 6'h00; w[5:0] = R_FN[$urandom_range(0, 15)]; end
      1: w[31:26] = 6'(8 + $urandom_range(0, 7));
      2: w[31:26] = $urandom_range(0, 1) ? 6'h23 : 6'h2B;
      3: if (k == 4) begin w[31:26] = 6'h01; w[20:16] = 5'($urandom_range(0, 1)); end
         else w[31:26] = 6'(4 + k);
      4: case (k % 4)
           0: w[31:26] = 6'h02;
           1: w[31:26] = 6'h03;
           2: begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
           default: begin w[31:26] = 6'h00; w[5:0] = 6'h09; end
         endcase
      default: begin
        case (k % 3)
          0: w[31:26] = 6'($urandom_range(16, 63));
          1: w[31:26] = 6'h00;
          default: begin w[31:26] = 6'h01; w[20:16] = 5'($urandom_range(2, 31)); end
        endcase
        for (int i = 0; i < 200 && classify(w).kind != K_ILL; i++) begin
          if (w[31:26] == 6'h00) w[5:0] = 6'($urandom);
          else w[31:26] = 6'($urandom_range(16, 63));
        end
      end
    endcase
    return w;
  endfunction

  // check outputs mid-cycle, then advance to 1 time unit after the next rising edge
  task automatic step(input string tag, input outs_t e, input bit chk_nt);
    #2;
    chk(tag, 32'(act), 32'(e));
    if (chk_nt) chk({tag, "/nt"}, 32'(act_nt), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("reset", 32'(act), 32'(base(4'd0)));
    chk("reset/nt", 32'(act_nt), 32'(base(4'd0)));
    @(posedge clk);
    #2 rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("release", 32'(act), 32'(e_fetch(1'b0)));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fst, input int mst, input int zs);
    info_t inf;
    int n;
    inf = classify(ins);
    instr = ins;
    n = (fst < 0) ? int'($urandom_range(0, 2)) : fst;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'b0; zero = 1'($urandom);
      step("fetch_stall", e_fetch(1'b0), 1'b1);
    end
    mem_ready = 1'b1;
    step("fetch", e_fetch(1'b1), 1'b1);
    mem_ready = 1'($urandom);
    step("decode", e_decode(), 1'b1);
    case (inf.kind)
      K_ALU: begin
        mem_ready = 1'($urandom);
        step("exec", e_exec(inf), 1'b1);
        mem_ready = 1'($urandom);
        step("wb", e_wb(inf.rtype), 1'b1);
      end
      K_LW, K_SW: begin
        mem_ready = 1'($urandom);
        step("memadr", e_memadr(), 1'b1);
        n = (mst < 0) ? int'($urandom_range(0, 2)) : mst;
        for (int i = 0; i < n; i++) begin
          mem_ready = 1'b0;
          step("mem_stall", e_mem(inf.kind == K_SW, 1'b0), 1'b1);
        end
        mem_ready = 1'b1;
        step("mem_done", e_mem(inf.kind == K_SW, 1'b1), 1'b1);
      end
      K_BR: begin
        zero = (zs < 0) ? 1'($urandom) : 1'(zs);
        mem_ready = 1'($urandom);
        step("branch", e_branch(inf, zero), 1'b1);
      end
      K_ILL: begin
        for (int i = 0; i < 3; i++) begin
          mem_ready = 1'($urandom);
          #2;
          chk("trap", 32'(act), 32'(e_trap()));
          if (i == 0) chk("nt_refetch", 32'(act_nt), 32'(e_fetch(mem_ready)));
          else        chk("nt_err", 32'(n_err), 32'd0);
          @(posedge clk);
          #1;
        end
        do_reset();
      end
      default: begin
        mem_ready = 1'($urandom);
        step("jump", e_jump(inf.kind), 1'b1);
      end
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; instr = 32'h0; zero = 1'b0; mem_ready = 1'b0;
    #2;
    chk("por", 32'(act), 32'(base(4'd0)));
    chk("por/nt", 32'(act_nt), 32'(base(4'd0)));
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // reset asserted while a load is waiting on memory
    instr = 32'h8C880004;
    mem_ready = 1'b1; step("t1_fetch", e_fetch(1'b1), 1'b1);
    mem_ready = 1'b0; step("t1_decode", e_decode(), 1'b1);
    step("t1_memadr", e_memadr(), 1'b1);
    step("t1_memrd", e_mem(1'b0, 1'b0), 1'b1);
    do_reset();

    // long fetch stall
    run_instr(32'h02328020, 3, 0, -1);
    // add with ready high throughout
    run_instr(32'h02328020, 0, 0, -1);
    // branches taken and not taken
    run_instr(32'h1000FFFF, 0, 0, 1);
    run_instr(32'h1000FFFF, 0, 0, 0);
    run_instr(32'h14000003, 0, 0, 1);
    run_instr(32'h14000003, 0, 0, 0);
    run_instr(32'h1C000010, 0, 0, 1);
    run_instr(32'h1C000010, 0, 0, 0);
    // lw with two memory stall cycles
    run_instr(32'h8C880004, 0, 2, -1);
    // illegal opcode 0x3F
    run_instr(32'hFC000000, 0, 0, -1);

    for (int t = 0; t < 80; t++)
      run_instr(gen_instr(int'($urandom_range(0, 5))), -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
